bitstream_loader: RTL

Programming controller for the fabric's BEL configuration chain. Takes configuration bytes from a valid/ready byte port and serializes them into the chain's `prog_clk` / `prog_en` / `prog_in` interface, generating `prog_clk` from the system clock. Also runs a non-destructive readback that recirculates the chain and returns its contents as bytes. Holds the fabric in reset until a full load completes. Sits between the chip-level I/O and the first BEL of the chain.

---
 rtl/bitstream_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bitstream_loader.sv
// Configuration-chain programmer: serializes bytes onto prog_clk/prog_en/prog_in
// and runs a recirculating, non-destructive readback of the chain.
module bitstream_loader #(
  parameter int CHAIN_LEN = 14,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_load,
  input  logic       start_read,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic       cfg_valid,
  output logic       fabric_rst
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOW, S_HIGH, S_EMIT, S_FINISH
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_mode_rd, w_mode_nxt;
  logic [BW-1:0]   r_bits, w_bits_nxt, w_bits_inc;
  logic [2:0]      r_bpos, w_bpos_nxt;
  logic [DW-1:0]   r_div, w_div_nxt;
  logic [7:0]      r_sr, w_sr_nxt;
  logic [7:0]      r_rb, w_rb_nxt;
  logic            r_cfg_valid, w_cfg_nxt;
  logic            w_div_last;

  logic            r_prog_clk, r_prog_en, r_prog_in;
  logic            r_in_ready, r_rd_valid, r_busy, r_done, r_fabric_rst;
  logic [7:0]      r_rd_data;

  assign w_bits_inc = r_bits + 1'b1;
  assign w_div_last = (r_div == DW'(CLK_DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode_rd;
    w_bits_nxt  = r_bits;
    w_bpos_nxt  = r_bpos;
    w_sr_nxt    = r_sr;
    w_rb_nxt    = r_rb;
    w_cfg_nxt   = r_cfg_valid;
    w_div_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (start_load) begin
          w_mode_nxt  = 1'b0;
          w_cfg_nxt   = 1'b0;
          w_bits_nxt  = '0;
          w_bpos_nxt  = '0;
          w_state_nxt = S_FETCH;
        end else if (start_read) begin
          w_mode_nxt  = 1'b1;
          w_bits_nxt  = '0;
          w_bpos_nxt  = '0;
          w_rb_nxt    = '0;
          w_state_nxt = S_LOW;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          w_sr_nxt    = in_data;
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          if (r_mode_rd) w_rb_nxt[r_bpos] = prog_out;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_bits_nxt = w_bits_inc;
          w_bpos_nxt = r_bpos + 3'd1;
          w_sr_nxt   = {1'b0, r_sr[7:1]};
          if (w_bits_inc == BW'(CHAIN_LEN))
            w_state_nxt = r_mode_rd ? S_EMIT : S_FINISH;
          else if (r_bpos == 3'd7)
            w_state_nxt = r_mode_rd ? S_EMIT : S_FETCH;
          else
            w_state_nxt = S_LOW;
        end
      end
      S_EMIT: begin
        if (rd_ready) begin
          w_rb_nxt    = '0;
          w_state_nxt = (r_bits == BW'(CHAIN_LEN)) ? S_FINISH : S_LOW;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // Load completion becomes visible in the same cycle as done.
    if (w_state_nxt == S_FINISH && r_state != S_FINISH && !w_mode_nxt)
      w_cfg_nxt = 1'b1;
    if (w_state_nxt == r_state && (r_state == S_LOW || r_state == S_HIGH))
      w_div_nxt = r_div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode_rd    <= 1'b0;
      r_bits       <= '0;
      r_bpos       <= '0;
      r_div        <= '0;
      r_sr         <= '0;
      r_rb         <= '0;
      r_cfg_valid  <= 1'b0;
      r_prog_clk   <= 1'b0;
      r_prog_en    <= 1'b0;
      r_prog_in    <= 1'b0;
      r_in_ready   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fabric_rst <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_rd   <= w_mode_nxt;
      r_bits      <= w_bits_nxt;
      r_bpos      <= w_bpos_nxt;
      r_div       <= w_div_nxt;
      r_sr        <= w_sr_nxt;
      r_rb        <= w_rb_nxt;
      r_cfg_valid <= w_cfg_nxt;
      // Outputs are decoded from the next state so they line up with r_state.
      r_prog_clk  <= (w_state_nxt == S_HIGH);
      if (w_state_nxt == S_LOW && r_state != S_LOW) begin
        r_prog_en <= 1'b1;
        r_prog_in <= w_mode_nxt ? prog_out : w_sr_nxt[0];
      end else if (w_state_nxt == S_FINISH) begin
        r_prog_en <= 1'b0;
      end
      r_in_ready <= (w_state_nxt == S_FETCH);
      r_rd_valid <= (w_state_nxt == S_EMIT);
      if (w_state_nxt == S_EMIT && r_state != S_EMIT)
        r_rd_data <= w_rb_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_FINISH);
      r_fabric_rst <= !w_cfg_nxt;
    end
  end

  assign prog_clk   = r_prog_clk;
  assign prog_en    = r_prog_en;
  assign prog_in    = r_prog_in;
  assign in_ready   = r_in_ready;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_valid  = r_cfg_valid;
  assign fabric_rst = r_fabric_rst;

endmodule
